// File: rtl/cdc_pkg.sv
// rtl/cdc_pkg.sv - shared FSM state type and default parameters for the CDC bus sender
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam int DEF_BUS_WIDTH      = 8;
  localparam int DEF_NUM_STAGES     = 2;
  localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/bit_sync.sv
// rtl/bit_sync.sv - multi-flop level synchronizer with asynchronous active-low reset
module bit_sync #(
  parameter int NUM_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  if (NUM_STAGES < 2) begin : g_bad_stages
    $error("bit_sync: NUM_STAGES must be at least 2");
  end

  logic [NUM_STAGES-1:0] sync;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync <= '0;
    end else begin
      sync <= {sync[NUM_STAGES-2:0], d};
    end
  end

  assign q = sync[NUM_STAGES-1];

endmodule

// File: rtl/cdc_bus_sender.sv
// rtl/cdc_bus_sender.sv - four-phase req/ack sender of a held bus into another clock domain
// Define CDC_TIMEOUT_EN to abort transfers whose ack does not arrive within TIMEOUT_CYCLES.
module cdc_bus_sender
  import cdc_pkg::*;
#(
  parameter int BUS_WIDTH      = DEF_BUS_WIDTH,
  parameter int NUM_STAGES     = DEF_NUM_STAGES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] data_in,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic [BUS_WIDTH-1:0] Unsync_bus,
  output logic                 bus_enable,
  input  logic                 ack_async,
  output logic                 tx_done,
  output logic                 tx_error
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("cdc_bus_sender: TIMEOUT_CYCLES must be at least 1");
  end

  state_t state;
  logic   ack_sync;

  bit_sync #(
    .NUM_STAGES(NUM_STAGES)
  ) u_ack_sync (
    .CLK(CLK),
    .RST(RST),
    .d  (ack_async),
    .q  (ack_sync)
  );

  // A lingering ack from the previous handshake must clear before a new request.
  assign data_ready = (state == IDLE) && !ack_sync;

`ifdef CDC_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             state_change;

  assign state_change = ((state == REQ) && ack_sync) || ((state == RELEASE) && !ack_sync);
`else
  assign tx_error = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      Unsync_bus <= '0;
      bus_enable <= 1'b0;
      tx_done    <= 1'b0;
`ifdef CDC_TIMEOUT_EN
      tx_error   <= 1'b0;
      wait_cnt   <= '0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (data_valid && data_ready) begin
            Unsync_bus <= data_in;
            bus_enable <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (ack_sync) begin
            bus_enable <= 1'b0;
            state      <= RELEASE;
          end
        end
        RELEASE: begin
          if (!ack_sync) begin
            tx_done <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          bus_enable <= 1'b0;
          state      <= IDLE;
        end
      endcase
`ifdef CDC_TIMEOUT_EN
      // A handshake step landing on the limit cycle wins over the abort.
      tx_error <= 1'b0;
      if ((state == IDLE) || state_change) begin
        wait_cnt <= '0;
      end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        state      <= IDLE;
        bus_enable <= 1'b0;
        tx_error   <= 1'b1;
        wait_cnt   <= '0;
      end else begin
        wait_cnt <= wait_cnt + 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_cdc_bus_sender.sv
// tb/tb_cdc_bus_sender.sv - randomized and directed checks of cdc_bus_sender against a transaction model
module tb_cdc_bus_sender;

  localparam int BW = 8;
  localparam int NS = 2;
`ifdef CDC_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 255;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [BW-1:0] data_in = '0;
  logic          data_valid = 1'b0;
  logic          data_ready;
  logic [BW-1:0] Unsync_bus;
  logic          bus_enable;
  logic          ack_async = 1'b0;
  logic          tx_done;
  logic          tx_error;

  cdc_bus_sender #(
    .BUS_WIDTH(BW),
    .NUM_STAGES(NS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .Unsync_bus(Unsync_bus),
    .bus_enable(bus_enable),
    .ack_async (ack_async),
    .tx_done   (tx_done),
    .tx_error  (tx_error)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Transaction model: phase 0 waiting for a word, 1 waiting for ack, 2 waiting for ack release.
  int          phase = 0;
  int          t_phase = 0;
  logic [BW-1:0] m_bus = '0;
  bit          m_en = 0;
  bit          m_done = 0;
  bit          m_err = 0;
  bit          ack_q[$];
  int          done_cnt = 0;
  int          err_cnt = 0;

  // The design sees ack as it was NS rising edges ago.
  function automatic bit ack_seen();
    if (ack_q.size() >= NS) return ack_q[ack_q.size() - NS];
    return 1'b0;
  endfunction

  task automatic model_edge();
    bit s;
    s = ack_seen();
    ack_q.push_back(ack_async);
    if (ack_q.size() > 8) void'(ack_q.pop_front());
    m_done = 0;
    m_err  = 0;
    case (phase)
      0: if (data_valid && !s) begin m_bus = data_in; m_en = 1; phase = 1; t_phase = 0; end
      1: if (s) begin m_en = 0; phase = 2; t_phase = 0; end else t_phase++;
      default: if (!s) begin m_done = 1; phase = 0; end else t_phase++;
    endcase
`ifdef CDC_TIMEOUT_EN
    if (phase != 0 && t_phase == TO) begin
      m_en = 0; m_err = 1; phase = 0; t_phase = 0;
    end
`endif
  endtask

  task automatic model_reset();
    phase = 0; t_phase = 0; m_bus = '0; m_en = 0; m_done = 0; m_err = 0;
    ack_q.delete();
  endtask

  task automatic compare_outputs();
    check("data_ready", data_ready, (phase == 0) && !ack_seen());
    check("bus_enable", bus_enable, m_en);
    check("Unsync_bus", Unsync_bus, m_bus);
    check("tx_done", tx_done, m_done);
    check("tx_error", tx_error, m_err);
  endtask

  task automatic tick();
    @(posedge CLK);
    if (RST) model_edge();
    else model_reset();
    @(negedge CLK);
    compare_outputs();
    done_cnt += int'(tx_done);
    err_cnt  += int'(tx_error);
  endtask

  int n;

  initial begin
    model_reset();
    repeat (2) @(negedge CLK);
    compare_outputs();
    RST = 1'b1;
    tick();

    // Basic transfer of A5 with a slow ack, and a rejected 3C offered mid-transfer.
    data_in = 8'hA5; data_valid = 1'b1;
    tick();
    check("a5_bus", Unsync_bus, 8'hA5);
    check("a5_en", bus_enable, 1);
    data_in = 8'h3C;
    tick(); tick();
    ack_async = 1'b1;
    n = 0;
    while (bus_enable && n < 10) begin tick(); n++; end
    check("en_fall_lat_ok", (n >= 2 && n <= 3), 1);
    data_valid = 1'b0;
    done_cnt = 0;
    repeat (4) tick();
    ack_async = 1'b0;
    n = 0;
    while (!tx_done && n < 10) begin tick(); n++; end
    check("done_lat_ok", (n >= 2 && n <= 3), 1);
    repeat (3) tick();
    check("done_pulses", done_cnt, 1);
    check("no_3c_sent", Unsync_bus, 8'hA5);

    // Stale ack in idle blocks new requests.
    ack_async = 1'b1;
    repeat (4) tick();
    check("ready_blocked", data_ready, 0);
    ack_async = 1'b0;
    n = 0;
    while (!data_ready && n < 10) begin tick(); n++; end
    check("ready_return_ok", (n >= 2 && n <= 3), 1);

    // Asynchronous reset in the middle of a request.
    data_in = 8'h5A; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    tick();
    check("pre_rst_en", bus_enable, 1);
    done_cnt = 0; err_cnt = 0;
    #2 RST = 1'b0;
    #1;
    check("rst_async_en", bus_enable, 0);
    check("rst_async_bus", Unsync_bus, 0);
    model_reset();
    tick(); tick();
    RST = 1'b1;
    repeat (4) tick();
    check("rst_no_done", done_cnt, 0);
    check("rst_no_err", err_cnt, 0);

`ifdef CDC_TIMEOUT_EN
    data_in = 8'h77; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    err_cnt = 0;
    n = 0;
    while (!tx_error && n < 40) begin tick(); n++; end
    check("timeout_lat", n, TO);
    check("timeout_en", bus_enable, 0);
    check("timeout_ready", data_ready, 1);
    repeat (3) tick();
    check("timeout_pulses", err_cnt, 1);
`endif

    // Random traffic with a randomly slow destination responder.
    for (int i = 0; i < 600; i++) begin
      data_valid = ($urandom_range(0, 1) == 1);
      data_in    = BW'($urandom);
      if (bus_enable && !ack_async && $urandom_range(0, 2) == 0) ack_async = 1'b1;
      else if (!bus_enable && ack_async && $urandom_range(0, 2) == 0) ack_async = 1'b0;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cdc_bus_sender.md
CDC_BUS_SENDER -- requirements
Module: cdc_bus_sender

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 8, width of the transferred bus.
REQ-002 SHALL have parameter NUM_STAGES, default 2, ack synchronizer depth; values below 2 are illegal.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, ack wait limit; used only with CDC_TIMEOUT_EN.
REQ-004 SHALL have port CLK  input  1  source-domain clock, rising edge.
REQ-005 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port data_in  input  BUS_WIDTH  word to send.
REQ-007 SHALL have port data_valid  input  1  data_in is offered this cycle.
REQ-008 SHALL have port data_ready  output  1  sender can accept a word this cycle.
REQ-009 SHALL have port Unsync_bus  output  BUS_WIDTH  registered bus to the destination domain, held stable during a transfer.
REQ-010 SHALL have port bus_enable  output  1  registered request level to the destination domain.
REQ-011 SHALL have port ack_async  input  1  acknowledge level from the destination domain, asynchronous to CLK.
REQ-012 SHALL have port tx_done  output  1  one-cycle pulse when a transfer completes.
REQ-013 SHALL have port tx_error  output  1  one-cycle pulse on timeout abort; tied 0 without CDC_TIMEOUT_EN.

Function
REQ-014 SHALL synchronize ack_async through NUM_STAGES flops to ack_sync before any use.
REQ-015 SHALL implement an FSM with states IDLE, REQ and RELEASE, encoded in a package enum.
REQ-016 SHALL assert data_ready combinationally only in IDLE.
REQ-017 SHALL capture data_in into Unsync_bus, set bus_enable=1 and enter REQ on the edge where data_valid and data_ready are both 1; both outputs are visible one cycle later.
REQ-018 SHALL hold Unsync_bus constant from capture until the FSM returns to IDLE.
REQ-019 SHALL stay in REQ while ack_sync=0; on ack_sync=1 it SHALL clear bus_enable and enter RELEASE.
REQ-020 SHALL stay in RELEASE while ack_sync=1; on ack_sync=0 it SHALL pulse tx_done for one cycle and enter IDLE.
REQ-021 SHALL ignore data_valid outside IDLE, with no capture and no queuing.
REQ-022 SHALL NOT start a new transfer in IDLE while ack_sync=1; data_ready SHALL be 0 until ack_sync=0.
REQ-023 SHALL accept a new word in the cycle after tx_done at the earliest.

Reset
REQ-024 SHALL on RST=0 immediately force state=IDLE, Unsync_bus=0, bus_enable=0, tx_done=0, tx_error=0, all synchronizer flops=0 and the timeout counter=0.
REQ-025 SHALL abandon any transfer in progress when reset is asserted mid-transfer, with no tx_done or tx_error pulse.

Configuration
REQ-026 With CDC_TIMEOUT_EN defined, SHALL count REQ and RELEASE cycles; when the count reaches TIMEOUT_CYCLES it SHALL clear bus_enable, pulse tx_error, zero the counter and enter IDLE.
REQ-027 With CDC_TIMEOUT_EN defined, the counter SHALL be ceil(log2(TIMEOUT_CYCLES+1)) bits and reset on every state change.
REQ-028 Without CDC_TIMEOUT_EN, SHALL contain no counter logic, hold tx_error at 0, and wait for ack indefinitely.

Structure
REQ-029 SHALL take the FSM state enum and default parameter constants from package cdc_pkg.
REQ-030 SHALL instantiate sub-module bit_sync (parameter NUM_STAGES, async-low reset) for the ack path.

Verification
REQ-031 Reset, then data_in=8'hA5 with data_valid=1 for one cycle -> next cycle Unsync_bus=8'hA5 and bus_enable=1; data_ready=0 until tx_done.
REQ-032 Raise ack_async 3 cycles after bus_enable, drop it 4 cycles after bus_enable falls -> bus_enable falls 2 to 3 CLK after the ack rises; exactly one tx_done pulse appears 2 to 3 CLK after the ack falls.
REQ-033 Drive data_in=8'h3C with data_valid=1 during REQ -> Unsync_bus stays 8'hA5 and 8'h3C is never sent.
REQ-034 Hold ack_async=1 while in IDLE -> data_ready=0 until 2 to 3 cycles after the ack drops.
REQ-035 Assert RST=0 mid-REQ -> bus_enable=0 and Unsync_bus=0 with no clock edge, and no tx_done pulse.
REQ-036 With CDC_TIMEOUT_EN and TIMEOUT_CYCLES=16, never ack -> tx_error pulses once 16 cycles after entering REQ, bus_enable=0, and data_ready returns to 1.
